sysbr_uart_tx: RTL and testbench

Memory-mapped UART transmitter on the IO side of the system bridge; it consumes the IO writes the bridge decodes and serialises them on `txd`. Software writes bytes into an 8-entry transmit FIFO. A bit-timing FSM drains the FIFO as 8N1 frames, and a level interrupt signals when the transmitter has drained. It is the first real device behind the bridge's IO port and replaces the bench's plain IO-write sink.

---
 rtl/sysbr_uart_tx_pkg.sv | 41 ++++
 rtl/sysbr_uart_tx_sync_fifo.sv | 61 ++++++
 rtl/sysbr_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_sysbr_uart_tx.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysbr_uart_tx_pkg.sv
// Shared definitions for the bridge-side UART transmitter: register map,
// STATUS/CTRL field positions, FSM encoding and the bit-period helper.
// Bus words are documented big-endian [0:31]; bit k of that numbering is
// numeric bit (31-k) here, so all positions below are numeric.
package sysbr_uart_tx_pkg;

  localparam int unsigned DATA_W      = 32;
  localparam int unsigned DIV_W       = 16;
  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned CNT_FIELD_W = 8;

  // Register selects on addr[3:2]
  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  // STATUS fields
  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_BUSY_BIT  = 2;
  localparam int unsigned STAT_OVF_BIT   = 3;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // CTRL fields
  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // A programmed divider of 0 behaves as 1 clock per bit
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_W'(1) : div;
  endfunction

endpackage

// File: rtl/sysbr_uart_tx_sync_fifo.sv
// Synchronous FIFO with occupancy count. A push while full is accepted only
// if a pop happens in the same cycle; pointers wrap modulo DEPTH.
module sysbr_uart_tx_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sysbr_uart_tx.sv
// Memory-mapped 8N1 UART transmitter behind the bridge IO port: register
// file, transmit FIFO, baud counter and bit-timing FSM.
module sysbr_uart_tx
  import sysbr_uart_tx_pkg::*;
#(
  parameter int unsigned      FIFO_DEPTH = 8,
  parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        addr,
  input  logic              wr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              txd,
  output logic              irq
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  tx_state_t         state;
  logic [BYTE_W-1:0] shreg;
  logic [2:0]        bit_idx;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DIV_W-1:0]  bauddiv;
  logic              en;
  logic              irq_en;
  logic              ovf;

  logic [1:0]        reg_sel;
  logic              wr_tx;
  logic              wr_stat;
  logic              wr_div;
  logic              wr_ctrl;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic              overflow;
  logic              busy;
  logic              bit_end;
  logic              unused_ok;

  assign reg_sel  = addr[3:2];
  assign wr_tx    = wr && (reg_sel == REG_TXDATA);
  assign wr_stat  = wr && (reg_sel == REG_STATUS);
  assign wr_div   = wr && (reg_sel == REG_BAUDDIV);
  assign wr_ctrl  = wr && (reg_sel == REG_CTRL);
  assign busy     = (state != ST_IDLE);
  assign fifo_pop = (state == ST_IDLE) && en && !fifo_empty;
  assign overflow = wr_tx && fifo_full && !fifo_pop;
  assign bit_end  = (baud_cnt <= DIV_W'(1));
  assign unused_ok = ^{addr[1:0], din[DATA_W-1:DIV_W]};

  sysbr_uart_tx_sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_tx),
    .wdata (din[BYTE_W-1:0]),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Control registers, sticky overflow flag and registered interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      en      <= 1'b0;
      irq_en  <= 1'b0;
      bauddiv <= DIV_RESET;
      ovf     <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        en     <= din[CTRL_EN_BIT];
        irq_en <= din[CTRL_IRQ_EN_BIT];
      end
      if (wr_div) begin
        bauddiv <= din[DIV_W-1:0];
      end
      if (overflow) begin
        ovf <= 1'b1;
      end else if (wr_stat && din[STAT_OVF_BIT]) begin
        ovf <= 1'b0;
      end
      irq <= irq_en & fifo_empty & ~busy;
    end
  end

  // Bit-timing FSM: pops a byte in IDLE and shifts it out as start/8 data/stop
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      shreg    <= '0;
      bit_idx  <= '0;
      baud_cnt <= '0;
      txd      <= 1'b1;
    end else begin
      // Divider is sampled only on reloads so a BAUDDIV write never cuts a bit short
      if (state != ST_IDLE) begin
        baud_cnt <= bit_end ? eff_div(bauddiv) : baud_cnt - DIV_W'(1);
      end
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state    <= ST_START;
            shreg    <= fifo_rdata;
            baud_cnt <= eff_div(bauddiv);
            txd      <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            bit_idx <= '0;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[BYTE_W-1:1]};
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
              state <= ST_STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[BYTE_W-1:1]};
            end
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Read mux; TXDATA and unused bits read as zero
  always_comb begin
    dout = '0;
    case (reg_sel)
      REG_STATUS: begin
        dout[STAT_EMPTY_BIT] = fifo_empty;
        dout[STAT_FULL_BIT]  = fifo_full;
        dout[STAT_BUSY_BIT]  = busy;
        dout[STAT_OVF_BIT]   = ovf;
        dout[STAT_COUNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(fifo_count);
      end
      REG_BAUDDIV: dout[DIV_W-1:0] = bauddiv;
      REG_CTRL: begin
        dout[CTRL_EN_BIT]     = en;
        dout[CTRL_IRQ_EN_BIT] = irq_en;
      end
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_sysbr_uart_tx.sv
// Directed self-checking bench for sysbr_uart_tx.
module tb_sysbr_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  addr;
  logic        wr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        txd;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  sysbr_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
    .clk(clk), .rst(rst), .addr(addr), .wr(wr), .din(din),
    .dout(dout), .txd(txd), .irq(irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // All tasks start and end just after a falling edge
  task automatic do_reset();
    rst = 1'b1; wr = 1'b0; addr = 4'h0; din = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; din = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; wr = 1'b0;
    #1;
    d = dout;
  endtask

  // Waits for a start bit and samples each bit in the middle of its period
  task automatic capture_frame(input int div, output logic [7:0] data,
                               output logic start_b, output logic stop_b,
                               output int start_cyc, output bit ok);
    int n;
    logic [9:0] bits;
    n = 0;
    while (txd !== 1'b0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = (txd === 1'b0);
    start_cyc = cyc;
    bits = '1;
    if (ok) begin
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? (div / 2) : div) @(negedge clk);
        bits[k] = txd;
      end
    end
    start_b = bits[0];
    data    = bits[8:1];
    stop_b  = bits[9];
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    do_reset();
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h0000_0001) begin n_fail++; $display("FAIL reset_status: got %h expected %h", rd, 32'h1); end
    reg_read(4'h8, rd);
    n_checks++; if (rd !== 32'd434) begin n_fail++; $display("FAIL reset_bauddiv: got %0d expected 434", rd); end
    reg_read(4'hC, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h expected 0", rd); end
    reg_read(4'h0, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL txdata_read: got %h expected 0", rd); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL reset_txd: got %b expected 1", txd); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
  endtask

  task automatic test_single_byte();
    logic [31:0] rd;
    logic [9:0]  frame;
    frame = {1'b1, 8'hA5, 1'b0};
    do_reset();
    reg_write(4'h8, 32'd4);
    reg_write(4'hC, 32'h1);
    reg_write(4'h0, 32'hA5);
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_pre_start: got %b expected 1", txd); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n_checks++;
      if (txd !== frame[i / 4]) begin n_fail++; $display("FAIL single_bit cycle %0d: got %b expected %b", i, txd, frame[i / 4]); end
    end
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL single_busy_last: got %h expected %h", rd, 32'h5); end
    @(negedge clk);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL single_busy_drop: got %h expected %h", rd, 32'h1); end
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL single_idle_txd: got %b expected 1", txd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd;
    logic [7:0]  d;
    logic        sb, pb;
    int          sc, lows;
    bit          ok;
    do_reset();
    reg_write(4'h8, 32'd2);
    for (int i = 1; i <= 9; i++) reg_write(4'h0, 32'(i));
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h0000_080A) begin n_fail++; $display("FAIL ovf_status_full: got %h expected %h", rd, 32'h80A); end
    reg_write(4'hC, 32'h1);
    for (int i = 1; i <= 8; i++) begin
      capture_frame(2, d, sb, pb, sc, ok);
      n_checks++;
      if (!ok || sb !== 1'b0 || pb !== 1'b1 || d !== 8'(i)) begin
        n_fail++; $display("FAIL ovf_frame %0d: got data %h start %b stop %b found %0d expected data %h", i, d, sb, pb, ok, 8'(i));
      end
    end
    repeat (5) @(negedge clk);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h9) begin n_fail++; $display("FAIL ovf_status_drained: got %h expected %h", rd, 32'h9); end
    lows = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL ovf_ninth_sent: got %0d low cycles expected 0", lows); end
    reg_write(4'h4, 32'h8);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL ovf_clear: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_push_pop_full();
    logic [31:0] rd;
    logic [7:0]  d;
    logic        sb, pb;
    int          sc;
    bit          ok;
    do_reset();
    reg_write(4'h8, 32'd2);
    for (int i = 0; i < 8; i++) reg_write(4'h0, 32'(8'h11 + i));
    reg_write(4'hC, 32'h1);
    reg_write(4'h0, 32'h19);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h0000_0806) begin n_fail++; $display("FAIL pushpop_status: got %h expected %h", rd, 32'h806); end
    for (int i = 0; i < 9; i++) begin
      capture_frame(2, d, sb, pb, sc, ok);
      n_checks++;
      if (!ok || sb !== 1'b0 || pb !== 1'b1 || d !== 8'(8'h11 + i)) begin
        n_fail++; $display("FAIL pushpop_frame %0d: got data %h found %0d expected %h", i, d, ok, 8'(8'h11 + i));
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd;
    logic [7:0]  d [3];
    logic        sb [3];
    logic        pb [3];
    int          sc [3];
    bit          ok [3];
    logic [7:0]  exp_d [3];
    exp_d[0] = 8'h3C; exp_d[1] = 8'h81; exp_d[2] = 8'hFF;
    do_reset();
    reg_write(4'h8, 32'd2);
    reg_write(4'hC, 32'h1);
    fork
      begin
        reg_write(4'h0, 32'h3C);
        reg_write(4'h0, 32'h81);
        reg_write(4'h0, 32'hFF);
      end
      begin
        for (int i = 0; i < 3; i++) capture_frame(2, d[i], sb[i], pb[i], sc[i], ok[i]);
      end
    join
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!ok[i] || sb[i] !== 1'b0 || pb[i] !== 1'b1 || d[i] !== exp_d[i]) begin
        n_fail++; $display("FAIL b2b_frame %0d: got data %h found %0d expected %h", i, d[i], ok[i], exp_d[i]);
      end
    end
    n_checks++; if (sc[1] - sc[0] != 21) begin n_fail++; $display("FAIL b2b_gap01: got %0d expected 21", sc[1] - sc[0]); end
    n_checks++; if (sc[2] - sc[1] != 21) begin n_fail++; $display("FAIL b2b_gap12: got %0d expected 21", sc[2] - sc[1]); end
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h5) begin n_fail++; $display("FAIL b2b_empty: got %h expected %h", rd, 32'h5); end
  endtask

  task automatic test_irq();
    int hi;
    do_reset();
    reg_write(4'h8, 32'd2);
    reg_write(4'hC, 32'h3);
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_idle: got %b expected 1", irq); end
    reg_write(4'h0, 32'h42);
    hi = 0;
    for (int i = 0; i < 21; i++) begin @(negedge clk); if (irq !== 1'b0) hi++; end
    n_checks++; if (hi != 0) begin n_fail++; $display("FAIL irq_during_frame: got %0d high cycles expected 0", hi); end
    @(negedge clk);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL irq_after_stop: got %b expected 1", irq); end
  endtask

  task automatic test_en_clear();
    logic [31:0] rd;
    logic [7:0]  d;
    logic        sb, pb;
    int          sc, lows;
    bit          ok;
    do_reset();
    reg_write(4'h8, 32'd2);
    reg_write(4'h0, 32'h5A);
    reg_write(4'h0, 32'h77);
    reg_write(4'hC, 32'h1);
    reg_write(4'hC, 32'h0);
    capture_frame(2, d, sb, pb, sc, ok);
    n_checks++;
    if (!ok || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h5A) begin
      n_fail++; $display("FAIL enclr_frame: got data %h found %0d expected 5a", d, ok);
    end
    repeat (5) @(negedge clk);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h0000_0100) begin n_fail++; $display("FAIL enclr_status: got %h expected %h", rd, 32'h100); end
    lows = 0;
    for (int i = 0; i < 40; i++) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL enclr_no_pop: got %0d low cycles expected 0", lows); end
  endtask

  task automatic test_div_zero();
    logic [31:0] rd;
    logic [7:0]  d;
    logic        sb, pb;
    int          sc;
    bit          ok;
    do_reset();
    reg_write(4'h8, 32'd0);
    reg_read(4'h8, rd);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL div0_readback: got %h expected 0", rd); end
    reg_write(4'hC, 32'h1);
    reg_write(4'h0, 32'h55);
    capture_frame(1, d, sb, pb, sc, ok);
    n_checks++;
    if (!ok || sb !== 1'b0 || pb !== 1'b1 || d !== 8'h55) begin
      n_fail++; $display("FAIL div0_frame: got data %h found %0d expected 55", d, ok);
    end
    @(negedge clk);
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL div0_frame_len: got %h expected %h", rd, 32'h1); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] rd;
    int          lows;
    do_reset();
    reg_write(4'h8, 32'd4);
    reg_write(4'hC, 32'h1);
    reg_write(4'h0, 32'hF0);
    reg_write(4'h0, 32'h12);
    reg_write(4'h0, 32'h34);
    repeat (16) @(negedge clk);
    n_checks++; if (txd !== 1'b0) begin n_fail++; $display("FAIL midrst_bit3: got %b expected 0", txd); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++; if (txd !== 1'b1) begin n_fail++; $display("FAIL midrst_txd: got %b expected 1", txd); end
    reg_read(4'h4, rd);
    n_checks++; if (rd !== 32'h1) begin n_fail++; $display("FAIL midrst_status: got %h expected %h", rd, 32'h1); end
    reg_write(4'h8, 32'd4);
    reg_write(4'hC, 32'h1);
    lows = 0;
    for (int i = 0; i < 60; i++) begin @(negedge clk); if (txd !== 1'b1) lows++; end
    n_checks++; if (lows != 0) begin n_fail++; $display("FAIL midrst_no_frames: got %0d low cycles expected 0", lows); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; addr = 4'h0; din = 32'h0;
    @(negedge clk);
    test_reset();
    test_single_byte();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_irq();
    test_en_clear();
    test_div_zero();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
